// File: rtl/pcie_tl_cfg_decoder.sv
// Decodes the PCIe HIP time-multiplexed config bus and status word into stable config and link-state registers.
// Optional LTSSM transition history ring buffer enabled by defining PCIE_TL_CFG_LTSSM_HIST_EN.
module pcie_tl_cfg_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int LD_CNT_W   = 16
) (
  input  logic                pld_clk_clk,
  input  logic                reset,
  input  logic [3:0]          tl_cfg_add,
  input  logic [31:0]         tl_cfg_ctl,
  input  logic [52:0]         tl_cfg_sts,
  output logic [15:0]         cfg_dev_ctl,
  output logic [15:0]         cfg_link_ctl,
  output logic [12:0]         cfg_busdev,
  output logic                cfg_valid,
  output logic [12:0]         max_payload_bytes,
  output logic [12:0]         max_rdreq_bytes,
  output logic [4:0]          ltssm,
  output logic                link_up,
  output logic [1:0]          link_speed,
  output logic [3:0]          lane_width,
  output logic [LD_CNT_W-1:0] link_down_cnt
`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
  ,
  input  logic [2:0]          hist_rd_idx,
  output logic [7:0]          hist_rd_data,
  output logic [3:0]          hist_count
`endif
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

  logic [3:0] add_p0;
  logic [3:0] stab_cnt;
  logic       strobe;
  logic       dev_seen;
  logic       link_seen;
  logic       busdev_seen;
  logic       link_up_p0;

  function automatic logic [12:0] size_bytes(input logic [2:0] code);
    if (code >= 3'd5) return 13'd4096;
    return 13'd128 << code;
  endfunction

  function automatic logic [3:0] lane_decode(input logic [3:0] lanes);
    if (lanes[0]) return 4'd1;
    if (lanes[1]) return 4'd2;
    if (lanes[2]) return 4'd4;
    if (lanes[3]) return 4'd8;
    return 4'd0;
  endfunction

  // Single-cycle strobe on the 3->4 style step; saturation prevents a second capture per dwell
  assign strobe = (tl_cfg_add == add_p0) && (stab_cnt == STABLE_MAX - 4'd1);

  always_ff @(posedge pld_clk_clk) begin
    if (reset) begin
      add_p0   <= 4'h0;
      stab_cnt <= 4'd0;
    end else begin
      add_p0 <= tl_cfg_add;
      if (tl_cfg_add != add_p0)
        stab_cnt <= 4'd0;
      else if (stab_cnt < STABLE_MAX)
        stab_cnt <= stab_cnt + 4'd1;
    end
  end

  always_ff @(posedge pld_clk_clk) begin
    if (reset) begin
      cfg_dev_ctl  <= 16'h0;
      cfg_link_ctl <= 16'h0;
      cfg_busdev   <= 13'h0;
      dev_seen     <= 1'b0;
      link_seen    <= 1'b0;
      busdev_seen  <= 1'b0;
      cfg_valid    <= 1'b0;
    end else begin
      if (strobe) begin
        case (tl_cfg_add)
          4'h0: begin
            cfg_dev_ctl <= tl_cfg_ctl[31:16];
            dev_seen    <= 1'b1;
          end
          4'h2: begin
            cfg_link_ctl <= tl_cfg_ctl[31:16];
            link_seen    <= 1'b1;
          end
          4'hF: begin
            cfg_busdev  <= tl_cfg_ctl[12:0];
            busdev_seen <= 1'b1;
          end
          default: ;
        endcase
      end
      cfg_valid <= dev_seen & link_seen & busdev_seen;
    end
  end

  // Size decode stage: held at zero until the config set is complete
  always_ff @(posedge pld_clk_clk) begin
    if (reset || !cfg_valid) begin
      max_payload_bytes <= 13'd0;
      max_rdreq_bytes   <= 13'd0;
    end else begin
      max_payload_bytes <= size_bytes(cfg_dev_ctl[7:5]);
      max_rdreq_bytes   <= size_bytes(cfg_dev_ctl[14:12]);
    end
  end

  always_ff @(posedge pld_clk_clk) begin
    if (reset) begin
      ltssm         <= 5'h0;
      link_speed    <= 2'b00;
      lane_width    <= 4'd0;
      link_up       <= 1'b0;
      link_up_p0    <= 1'b0;
      link_down_cnt <= '0;
    end else begin
      ltssm      <= tl_cfg_sts[50:46];
      link_speed <= tl_cfg_sts[32:31];
      lane_width <= lane_decode(tl_cfg_sts[38:35]);
      link_up    <= (ltssm == 5'h0F);
      link_up_p0 <= link_up;
      if (link_up_p0 && !link_up && (link_down_cnt != '1))
        link_down_cnt <= link_down_cnt + LD_CNT_W'(1);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{tl_cfg_sts[52:51], tl_cfg_sts[45:39], tl_cfg_sts[34:33],
                         tl_cfg_sts[30:0], tl_cfg_ctl[15:13]};

`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
  logic [4:0] ltssm_p0;
  logic [7:0] hist_mem [8];
  logic [2:0] wr_ptr;

  // History write trails the registered ltssm by one cycle
  always_ff @(posedge pld_clk_clk) begin
    if (reset) begin
      ltssm_p0   <= 5'h0;
      wr_ptr     <= 3'd0;
      hist_count <= 4'd0;
      for (int i = 0; i < 8; i++) hist_mem[i] <= 8'h0;
    end else begin
      ltssm_p0 <= ltssm;
      if (ltssm != ltssm_p0) begin
        hist_mem[wr_ptr] <= {ltssm, 3'b000};
        wr_ptr           <= wr_ptr + 3'd1;
        if (hist_count != 4'd8) hist_count <= hist_count + 4'd1;
      end
    end
  end

  assign hist_rd_data = hist_mem[wr_ptr - 3'd1 - hist_rd_idx];
`endif

endmodule

// File: tb/tb_pcie_tl_cfg_decoder.sv
// Directed bench for pcie_tl_cfg_decoder: config capture, size decode, link status, reset behaviour.
// A second instance with LD_CNT_W=2 shares the status stimulus to exercise counter saturation.
module tb_pcie_tl_cfg_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  tl_cfg_add;
  logic [31:0] tl_cfg_ctl;
  logic [52:0] tl_cfg_sts;
  logic [15:0] cfg_dev_ctl;
  logic [15:0] cfg_link_ctl;
  logic [12:0] cfg_busdev;
  logic        cfg_valid;
  logic [12:0] max_payload_bytes;
  logic [12:0] max_rdreq_bytes;
  logic [4:0]  ltssm;
  logic        link_up;
  logic [1:0]  link_speed;
  logic [3:0]  lane_width;
  logic [15:0] link_down_cnt;
  logic [1:0]  link_down_cnt_w2;

  logic [15:0] unused_dev, unused_link;
  logic [12:0] unused_busdev, unused_pay, unused_rd;
  logic        unused_valid, unused_up;
  logic [4:0]  unused_ltssm;
  logic [1:0]  unused_speed;
  logic [3:0]  unused_lanes;

`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
  logic [2:0] hist_rd_idx = 3'd0;
  logic [7:0] hist_rd_data;
  logic [3:0] hist_count;
  logic [2:0] hist_rd_idx_w2 = 3'd0;
  logic [7:0] unused_hist_data;
  logic [3:0] unused_hist_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_tl_cfg_decoder #(.STABLE_CYC(4), .LD_CNT_W(16)) dut (
    .pld_clk_clk(clk), .reset(reset),
    .tl_cfg_add(tl_cfg_add), .tl_cfg_ctl(tl_cfg_ctl), .tl_cfg_sts(tl_cfg_sts),
    .cfg_dev_ctl(cfg_dev_ctl), .cfg_link_ctl(cfg_link_ctl), .cfg_busdev(cfg_busdev),
    .cfg_valid(cfg_valid), .max_payload_bytes(max_payload_bytes),
    .max_rdreq_bytes(max_rdreq_bytes), .ltssm(ltssm), .link_up(link_up),
    .link_speed(link_speed), .lane_width(lane_width), .link_down_cnt(link_down_cnt)
`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
    , .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data), .hist_count(hist_count)
`endif
  );

  pcie_tl_cfg_decoder #(.STABLE_CYC(4), .LD_CNT_W(2)) dut_w2 (
    .pld_clk_clk(clk), .reset(reset),
    .tl_cfg_add(tl_cfg_add), .tl_cfg_ctl(tl_cfg_ctl), .tl_cfg_sts(tl_cfg_sts),
    .cfg_dev_ctl(unused_dev), .cfg_link_ctl(unused_link), .cfg_busdev(unused_busdev),
    .cfg_valid(unused_valid), .max_payload_bytes(unused_pay),
    .max_rdreq_bytes(unused_rd), .ltssm(unused_ltssm), .link_up(unused_up),
    .link_speed(unused_speed), .lane_width(unused_lanes), .link_down_cnt(link_down_cnt_w2)
`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
    , .hist_rd_idx(hist_rd_idx_w2), .hist_rd_data(unused_hist_data),
    .hist_count(unused_hist_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [52:0] mk_sts(input logic [4:0] lt, input logic [3:0] lanes,
                                         input logic [1:0] speed);
    logic [52:0] s;
    s = '0;
    s[50:46] = lt;
    s[38:35] = lanes;
    s[32:31] = speed;
    return s;
  endfunction

  initial begin
    reset      = 1'b1;
    tl_cfg_add = 4'h0;
    tl_cfg_ctl = 32'h2020_0000;
    tl_cfg_sts = '0;
    step(2);
    check("rst_dev_ctl", 32'(cfg_dev_ctl), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_payload", 32'(max_payload_bytes), 32'h0);
    check("rst_down_cnt", 32'(link_down_cnt), 32'h0);

    // add 0 already held through reset: capture on the fourth edge after release
    reset = 1'b0;
    step(3);
    check("dev_before_dwell", 32'(cfg_dev_ctl), 32'h0);
    step(1);
    check("dev_capture", 32'(cfg_dev_ctl), 32'h2020);
    check("valid_partial", 32'(cfg_valid), 32'h0);
    step(1);
    check("payload_gated", 32'(max_payload_bytes), 32'h0);

    // toggling address never reaches the strobe
    for (int i = 0; i < 8; i++) begin
      tl_cfg_add = (i % 2 == 1) ? 4'h2 : 4'h0;
      tl_cfg_ctl = 32'hFFFF_FFFF;
      step(1);
    end
    check("toggle_dev", 32'(cfg_dev_ctl), 32'h2020);
    check("toggle_link", 32'(cfg_link_ctl), 32'h0);
    check("toggle_valid", 32'(cfg_valid), 32'h0);

    tl_cfg_add = 4'h0; tl_cfg_ctl = 32'h0000_0000;
    step(5);
    check("dev_zero", 32'(cfg_dev_ctl), 32'h0);
    tl_cfg_add = 4'h2; tl_cfg_ctl = 32'h0040_0000;
    step(4);
    check("link_early", 32'(cfg_link_ctl), 32'h0);
    step(1);
    check("link_capture", 32'(cfg_link_ctl), 32'h0040);
    tl_cfg_add = 4'hF; tl_cfg_ctl = 32'h0000_0123;
    step(5);
    check("busdev_capture", 32'(cfg_busdev), 32'h123);
    check("valid_lag", 32'(cfg_valid), 32'h0);
    step(1);
    check("valid_set", 32'(cfg_valid), 32'h1);
    step(1);
    check("payload_128", 32'(max_payload_bytes), 32'd128);
    check("rdreq_128", 32'(max_rdreq_bytes), 32'd128);
    tl_cfg_ctl = 32'h0000_1FFF;
    step(6);
    check("one_capture_per_dwell", 32'(cfg_busdev), 32'h123);

    // ctl changes mid-dwell; value on the strobe cycle is what lands
    tl_cfg_add = 4'h0; tl_cfg_ctl = 32'hDEAD_0000;
    step(4);
    tl_cfg_ctl = 32'h20E0_0000;
    step(1);
    check("dev_strobe_value", 32'(cfg_dev_ctl), 32'h20E0);
    step(1);
    check("payload_sat", 32'(max_payload_bytes), 32'd4096);
    check("rdreq_512", 32'(max_rdreq_bytes), 32'd512);
    check("valid_sticky", 32'(cfg_valid), 32'h1);

    tl_cfg_sts = mk_sts(5'h0F, 4'b1100, 2'b11);
    step(1);
    check("ltssm_reg", 32'(ltssm), 32'h0F);
    check("lane_x4", 32'(lane_width), 32'd4);
    check("speed_gen3", 32'(link_speed), 32'd3);
    check("link_up_lag", 32'(link_up), 32'h0);
    step(2);
    check("link_up", 32'(link_up), 32'h1);
    tl_cfg_sts = mk_sts(5'h00, 4'b1100, 2'b11); step(3);
    tl_cfg_sts = mk_sts(5'h0F, 4'b1100, 2'b11); step(3);
    check("rise_no_count", 32'(link_down_cnt), 32'd1);
    tl_cfg_sts = mk_sts(5'h00, 4'b1100, 2'b11); step(3);
    check("down_cnt_2", 32'(link_down_cnt), 32'd2);

    tl_cfg_sts = mk_sts(5'h00, 4'b1010, 2'b01); step(1);
    check("lane_x2", 32'(lane_width), 32'd2);
    check("speed_gen1", 32'(link_speed), 32'd1);
    tl_cfg_sts = mk_sts(5'h00, 4'b1000, 2'b10); step(1);
    check("lane_x8", 32'(lane_width), 32'd8);
    tl_cfg_sts = mk_sts(5'h00, 4'b0000, 2'b10); step(1);
    check("lane_none", 32'(lane_width), 32'd0);

    for (int i = 0; i < 3; i++) begin
      tl_cfg_sts = mk_sts(5'h0F, 4'b0001, 2'b01); step(3);
      tl_cfg_sts = mk_sts(5'h00, 4'b0001, 2'b01); step(3);
    end
    check("down_cnt_5", 32'(link_down_cnt), 32'd5);
    check("down_cnt_w2_sat", 32'(link_down_cnt_w2), 32'd3);

    // reset two cycles into a dwell abandons it
    tl_cfg_add = 4'h2; tl_cfg_ctl = 32'h1234_0000;
    step(2);
    reset = 1'b1;
    step(1);
    check("mid_rst_dev", 32'(cfg_dev_ctl), 32'h0);
    check("mid_rst_link", 32'(cfg_link_ctl), 32'h0);
    check("mid_rst_busdev", 32'(cfg_busdev), 32'h0);
    check("mid_rst_valid", 32'(cfg_valid), 32'h0);
    check("mid_rst_payload", 32'(max_payload_bytes), 32'h0);
    check("mid_rst_down", 32'(link_down_cnt), 32'h0);
    reset = 1'b0;
    step(4);
    check("post_rst_no_early", 32'(cfg_link_ctl), 32'h0);
    step(1);
    check("post_rst_capture", 32'(cfg_link_ctl), 32'h1234);

`ifdef PCIE_TL_CFG_LTSSM_HIST_EN
    for (int i = 1; i <= 10; i++) begin
      tl_cfg_sts = mk_sts(5'(i), 4'b0000, 2'b00);
      step(2);
    end
    step(1);
    check("hist_count_sat", 32'(hist_count), 32'd8);
    hist_rd_idx = 3'd0; #1;
    check("hist_latest", 32'(hist_rd_data), 32'h50);
    hist_rd_idx = 3'd1; #1;
    check("hist_prev", 32'(hist_rd_data), 32'h48);
    hist_rd_idx = 3'd7; #1;
    check("hist_oldest", 32'(hist_rd_data), 32'h18);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
